// File: rtl/push_button_debouncer.sv
// Debounces raw push-button and switch levels on the 100 MHz board clock.
// Each channel has a two-flop synchronizer and a STABLE/COUNTING debounce FSM.
// Each channel drives a debounced level, one-cycle rise and fall pulses, and
// a level that inverts on every accepted press.
module push_button_debouncer #(
    parameter int NUM_BUTTONS    = 3,
    parameter int DEBOUNCE_COUNT = 1000000,
    parameter int CNT_WIDTH      = 20
) (
    input  logic                   Clock_100MHz,
    input  logic                   Clear_n,
    input  logic [NUM_BUTTONS-1:0] Buttons_in,
    output logic [NUM_BUTTONS-1:0] Buttons_out,
    output logic [NUM_BUTTONS-1:0] Buttons_rise,
    output logic [NUM_BUTTONS-1:0] Buttons_fall,
    output logic [NUM_BUTTONS-1:0] Buttons_toggle
);

    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } state_e;

    // A new level is accepted on the edge where the counter already holds this
    // value, so the level has been seen on DEBOUNCE_COUNT consecutive edges.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_COUNT - 1);

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_ch
        logic                 sync1_q, sync2_q;
        state_e               state_q, state_d;
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
        logic                 out_q, out_d;
        logic                 rise_q, rise_d;
        logic                 fall_q, fall_d;
        logic                 toggle_q, toggle_d;

        // Two-flop synchronizer; only sync2_q feeds the debounce logic.
        always_ff @(posedge Clock_100MHz or negedge Clear_n) begin
            if (!Clear_n) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
            end else begin
                // NOTE: non-blocking assignments make sync2_q take the old
                // sync1_q, giving two real flop stages instead of a single wire.
                sync1_q <= Buttons_in[g];
                sync2_q <= sync1_q;
            end
        end

        // Debounce state, counter and all registered outputs.
        always_ff @(posedge Clock_100MHz or negedge Clear_n) begin
            if (!Clear_n) begin
                state_q  <= STABLE;
                cnt_q    <= '0;
                out_q    <= 1'b0;
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
                toggle_q <= 1'b0;
            end else begin
                state_q  <= state_d;
                cnt_q    <= cnt_d;
                out_q    <= out_d;
                rise_q   <= rise_d;
                fall_q   <= fall_d;
                toggle_q <= toggle_d;
            end
        end

        // Next-state logic: count consecutive mismatches and accept on the last.
        always_comb begin
            // NOTE: every output gets a default first, so no path through the
            // case statement leaves a signal unassigned and infers a latch.
            state_d  = state_q;
            cnt_d    = cnt_q;
            out_d    = out_q;
            rise_d   = 1'b0;
            fall_d   = 1'b0;
            toggle_d = toggle_q;
            case (state_q)
                STABLE: begin
                    if (sync2_q != out_q) begin
                        state_d = COUNTING;
                        cnt_d   = CNT_WIDTH'(1);
                    end else begin
                        cnt_d = '0;
                    end
                end
                COUNTING: begin
                    if (sync2_q == out_q) begin
                        // Bounced back to the accepted level: discard the count.
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        // Accept; the counter clears here, so it never wraps.
                        state_d = STABLE;
                        cnt_d   = '0;
                        out_d   = sync2_q;
                        rise_d  = sync2_q;
                        fall_d  = ~sync2_q;
                        if (sync2_q) begin
                            toggle_d = ~toggle_q;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end
            endcase
        end

        assign Buttons_out[g]    = out_q;
        assign Buttons_rise[g]   = rise_q;
        assign Buttons_fall[g]   = fall_q;
        assign Buttons_toggle[g] = toggle_q;
    end

endmodule

// File: tb/tb_push_button_debouncer.sv
// Directed bench for push_button_debouncer with DEBOUNCE_COUNT=4, CNT_WIDTH=3.
// A clean edge driven between clocks is accepted on the 6th rising edge after it.
module tb_push_button_debouncer;

    localparam int NB = 3;

    logic          clk;
    logic          rst_n;
    logic [NB-1:0] btn_in;
    logic [NB-1:0] btn_out, btn_rise, btn_fall, btn_toggle;

    int checks = 0;
    int errors = 0;

    // Pulse counters kept by the monitor below.
    int rise_cnt [NB];
    int fall_cnt [NB];
    int both_cnt;
    int r0_base, f0_base, r1_base, r2_base;

    push_button_debouncer #(
        .NUM_BUTTONS   (NB),
        .DEBOUNCE_COUNT(4),
        .CNT_WIDTH     (3)
    ) dut (
        .Clock_100MHz  (clk),
        .Clear_n       (rst_n),
        .Buttons_in    (btn_in),
        .Buttons_out   (btn_out),
        .Buttons_rise  (btn_rise),
        .Buttons_fall  (btn_fall),
        .Buttons_toggle(btn_toggle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count pulses away from the active edge.
    initial begin
        both_cnt = 0;
        for (int i = 0; i < NB; i++) begin
            rise_cnt[i] = 0;
            fall_cnt[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NB; i++) begin
                if (btn_rise[i]) rise_cnt[i]++;
                if (btn_fall[i]) fall_cnt[i]++;
                if (btn_rise[i] && btn_fall[i]) both_cnt++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out"},    32'(btn_out),    32'h0);
        check({tag, "_rise"},   32'(btn_rise),   32'h0);
        check({tag, "_fall"},   32'(btn_fall),   32'h0);
        check({tag, "_toggle"}, 32'(btn_toggle), 32'h0);
    endtask

    initial begin
        // ---------------- Reset with all inputs high ----------------
        rst_n  = 1'b0;
        btn_in = 3'b111;
        #3;
        check_all_zero("rst_async");
        tick(3);
        check_all_zero("rst_held");
        rst_n = 1'b1;
        tick(5);
        check("rst_out_e5", 32'(btn_out), 32'h0);
        tick(1);
        check("rst_out_e6",    32'(btn_out),    32'h7);
        check("rst_rise_e6",   32'(btn_rise),   32'h7);
        check("rst_toggle_e6", 32'(btn_toggle), 32'h7);
        tick(1);
        check("rst_rise_e7", 32'(btn_rise), 32'h0);
        check("rst_out_e7",  32'(btn_out),  32'h7);

        // All released together: simultaneous fall pulses, toggles hold.
        btn_in = 3'b000;
        tick(6);
        check("all_fall_out",    32'(btn_out),    32'h0);
        check("all_fall_pulse",  32'(btn_fall),   32'h7);
        check("all_fall_toggle", 32'(btn_toggle), 32'h7);
        tick(1);
        check("all_fall_clear", 32'(btn_fall), 32'h0);

        // Clear toggles for the following scenarios.
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("reclear_toggle", 32'(btn_toggle), 32'h0);

        // ---------------- Clean press / release on channel 0 ----------------
        r0_base = rise_cnt[0];
        f0_base = fall_cnt[0];
        btn_in[0] = 1'b1;
        tick(5);
        check("press_out_e5",  32'(btn_out),  32'h0);
        check("press_rise_e5", 32'(btn_rise), 32'h0);
        tick(1);
        check("press_out_e6",    32'(btn_out),    32'h1);
        check("press_rise_e6",   32'(btn_rise),   32'h1);
        check("press_toggle_e6", 32'(btn_toggle), 32'h1);
        tick(1);
        check("press_rise_e7", 32'(btn_rise), 32'h0);
        btn_in[0] = 1'b0;
        tick(5);
        check("release_out_e5",  32'(btn_out),  32'h1);
        check("release_fall_e5", 32'(btn_fall), 32'h0);
        tick(1);
        check("release_out_e6",    32'(btn_out),    32'h0);
        check("release_fall_e6",   32'(btn_fall),   32'h1);
        check("release_toggle_e6", 32'(btn_toggle), 32'h1);
        tick(1);
        check("release_fall_e7", 32'(btn_fall), 32'h0);

        // ---------------- Toggle: two more press/release pairs ----------------
        btn_in[0] = 1'b1;
        tick(7);
        check("toggle_2nd", 32'(btn_toggle[0]), 32'h0);
        btn_in[0] = 1'b0;
        tick(7);
        btn_in[0] = 1'b1;
        tick(7);
        check("toggle_3rd", 32'(btn_toggle[0]), 32'h1);
        btn_in[0] = 1'b0;
        tick(7);
        check("toggle_rises", 32'(rise_cnt[0] - r0_base), 32'd3);
        check("toggle_falls", 32'(fall_cnt[0] - f0_base), 32'd3);

        // ---------------- Bounce on channel 1 ----------------
        r1_base = rise_cnt[1];
        for (int k = 0; k < 2; k++) begin
            btn_in[1] = 1'b1;
            tick(2);
            btn_in[1] = 1'b0;
            tick(2);
        end
        btn_in[1] = 1'b1;
        check("bounce_quiet_out",  32'(btn_out[1]),               32'h0);
        check("bounce_quiet_rise", 32'(rise_cnt[1] - r1_base),    32'd0);
        tick(5);
        check("bounce_out_e5", 32'(btn_out[1]), 32'h0);
        tick(1);
        check("bounce_out_e6",  32'(btn_out[1]),  32'h1);
        check("bounce_rise_e6", 32'(btn_rise),    32'h2);
        tick(1);
        check("bounce_single_rise", 32'(rise_cnt[1] - r1_base), 32'd1);

        // ---------------- 3-cycle glitch on channel 2 ----------------
        r2_base = rise_cnt[2];
        btn_in[2] = 1'b1;
        tick(3);
        btn_in[2] = 1'b0;
        tick(8);
        check("glitch_out",    32'(btn_out[2]),            32'h0);
        check("glitch_toggle", 32'(btn_toggle[2]),         32'h0);
        check("glitch_rises",  32'(rise_cnt[2] - r2_base), 32'd0);

        // ---------------- Mid-count reset on channel 1 ----------------
        btn_in[1] = 1'b0;
        tick(7);
        check("mid_pre_out",    32'(btn_out),    32'h0);
        check("mid_pre_toggle", 32'(btn_toggle), 32'h3);
        btn_in[1] = 1'b1;
        tick(4);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_async");
        tick(1);
        rst_n = 1'b1;
        tick(5);
        check("mid_out_e5", 32'(btn_out), 32'h0);
        tick(1);
        check("mid_out_e6",    32'(btn_out),    32'h2);
        check("mid_rise_e6",   32'(btn_rise),   32'h2);
        check("mid_toggle_e6", 32'(btn_toggle), 32'h2);
        tick(1);
        check("mid_rise_e7", 32'(btn_rise), 32'h0);

        check("never_rise_and_fall", 32'(both_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/push_button_debouncer.md
Name: push_button_debouncer

Overview:
- Conditions raw board push-buttons and switches (Load, Up_down, Enable) before they reach counter_FFFFFFFF and the clock divider.
- Each channel gets a 2-flop synchronizer, a per-channel debounce counter, and a debounced level output.
- Each channel also produces one-cycle rise/fall pulses and a press-toggled level, so a momentary button can act as a latching Up_down control.
- Runs entirely on the 100 MHz board clock.

Parameters:
- NUM_BUTTONS, 3, number of independent input channels.
- DEBOUNCE_COUNT, 1000000, consecutive stable cycles required to accept a new level (10 ms at 100 MHz); legal range is 2 to 2^CNT_WIDTH-1.
- CNT_WIDTH, 20, width of each per-channel debounce counter.

Ports:
- Clock_100MHz  input  1  system clock; all state changes on its rising edge.
- Clear_n  input  1  asynchronous, active-low reset.
- Buttons_in  input  NUM_BUTTONS  raw asynchronous button/switch levels.
- Buttons_out  output  NUM_BUTTONS  debounced level per channel.
- Buttons_rise  output  NUM_BUTTONS  one-cycle pulse when a debounced 0->1 is accepted.
- Buttons_fall  output  NUM_BUTTONS  one-cycle pulse when a debounced 1->0 is accepted.
- Buttons_toggle  output  NUM_BUTTONS  level that inverts on every accepted rise.

Behaviour:
- Reset: one clock, Clock_100MHz; reset Clear_n is asynchronous and active-low. While Clear_n=0, the following are all 0 immediately, with no clock needed:
  - sync flops, debounce counters, state;
  - Buttons_out, Buttons_rise, Buttons_fall, Buttons_toggle.
- Synchronizer: two flops per channel, sync1 <= Buttons_in and sync2 <= sync1. Only sync2 is used downstream; no raw input reaches any other logic.
- Per-channel FSM, states STABLE and COUNTING; reset state is STABLE with cnt=0.
  - STABLE: if sync2 == Buttons_out, stay and hold cnt=0. If sync2 != Buttons_out, go to COUNTING with cnt=1.
  - COUNTING, sync2 == Buttons_out (bounce back): go to STABLE, cnt=0, no output change.
  - COUNTING, sync2 != Buttons_out, cnt < DEBOUNCE_COUNT-1: cnt increments.
  - COUNTING, sync2 != Buttons_out, cnt == DEBOUNCE_COUNT-1: accept.
- Accept actions (all registered on the same edge):
  - Buttons_out <= sync2; next state STABLE; cnt=0.
  - Buttons_rise (if new level is 1) or Buttons_fall (if 0) is 1 for exactly the next cycle.
  - On a rise, Buttons_toggle inverts.
- Latency: an input edge held clean produces the Buttons_out change and the pulse DEBOUNCE_COUNT+2 cycles after the first Buttons_in sample of the new level (2 sync + DEBOUNCE_COUNT).
- Pulses:
  - Never wider than 1 cycle; Buttons_rise and Buttons_fall are never both 1 on the same channel.
  - Minimum spacing between a rise and the next fall on a channel is DEBOUNCE_COUNT cycles.
- Channels are fully independent. Simultaneous accepts on several channels all pulse in the same cycle.
- Counter never wraps: it saturates at DEBOUNCE_COUNT-1 by construction, because accept clears it.
- Reset asserted mid-count clears everything. After release, an input already held at 1 needs the full 2+DEBOUNCE_COUNT cycles to be accepted, and that accept produces a rise pulse and a toggle.
- Glitches shorter than DEBOUNCE_COUNT cycles produce no output activity.

Test Plan:
All scenarios run with DEBOUNCE_COUNT=4, CNT_WIDTH=3, NUM_BUTTONS=3.
- Reset: Clear_n=0 with Buttons_in=3'b111 -> all outputs 0 asynchronously. Release Clear_n -> Buttons_out=3'b111 6 cycles after release; Buttons_rise=3'b111 for 1 cycle; Buttons_toggle=3'b111.
- Clean press: Buttons_in[0] 0->1 held -> Buttons_out[0]=1 and Buttons_rise[0]=1 exactly 6 cycles later, for 1 cycle; Buttons_toggle[0] 0->1. Release -> Buttons_fall[0] 1 cycle after 6 cycles; toggle stays 1.
- Bounce: Buttons_in[1] toggles 1,0,1,0 on successive 2-cycle intervals, then settles at 1 -> no output activity during bounce; a single rise 6 cycles after the final 0->1 edge.
- Glitch: 3-cycle high pulse on Buttons_in[2] -> Buttons_out, Buttons_rise and Buttons_toggle unchanged.
- Toggle: three clean presses/releases on channel 0 -> Buttons_toggle[0] sequence 1,0,1; exactly 3 rise and 3 fall pulses.
- Mid-operation reset: Clear_n low for 1 cycle while channel 1 is at cnt=2 -> all outputs 0, FSM in STABLE. Input still high -> re-accepted 6 cycles after release with one rise pulse.
